kalman_gain_seq: RTL and testbench
==================================

Name: kalman_gain_seq

Overview:
- Stage directly downstream of the 2x2 prior-covariance stage in the KF datapath.
- Assumes a scalar position measurement, H = [1 0].
- Computes the innovation covariance S = P_PRIOR00 + r and the Kalman gain K = [P_PRIOR00/S ; P_PRIOR10/S].
- Uses one shared bit-serial restoring divider, run twice in sequence; results go to the posterior update stage.

Parameters:
- N, 20, total fixed-point width (signed two's complement).
- FRAC, 10, fractional bits; 1.0 = 2^FRAC.

Ports:
- clk  in  1  single clock, all flops on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- p00  in  N  P_PRIOR00 from the prior stage.
- p10  in  N  P_PRIOR10 from the prior stage.
- r  in  N  measurement noise variance.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- div_err  out  1  S <= 0 on the last run; held until the next accepted start.
- S_INNOV  out  N  innovation covariance, saturated to N bits.
- K0  out  N  gain for the position state.
- K1  out  N  gain for the velocity state.

Behaviour:
- Interface: one clock (clk); asynchronous, active-high reset (rst).
- Reset: all outputs are 0; state is IDLE. Reset asserted mid-operation aborts immediately to IDLE with outputs 0 and no done pulse.
- FSM states: IDLE, SUM, DIV0, DIV1, FIN.
- IDLE: when start=1, capture p00, p10 and r into registers and go to SUM. Inputs are not required to stay stable after that.
  - start while busy is ignored and not queued.
- SUM (1 cycle):
  - s = p00 + r computed in N+1 bits, held internally at N+1.
  - S_INNOV = s saturated to [-2^(N-1), 2^(N-1)-1].
  - If s <= 0: div_err=1, K0=K1=0, go to FIN.
  - Otherwise clear div_err and go to DIV0.
- DIV0 (DIV_ITERS cycles):
  - Numerator magnitude is |p00| << FRAC (N+FRAC bits); divisor is s (N+1 bits).
  - Restoring division produces one quotient bit per cycle, MSB first.
  - Apply the sign of the numerator afterwards.
  - Saturate the quotient to the signed N-bit range, write it to K0, go to DIV1.
- DIV1: same procedure with p10; result written to K1; go to FIN.
- FIN (1 cycle): done=1, busy=0, return to IDLE.
  - start is accepted again in the cycle done is high (back-to-back operation).
- Latency:
  - Nominal: DIV_ITERS = N+FRAC = 30. With start sampled at edge E0, done is high during the cycle after edge 3 + 2*DIV_ITERS = 63.
  - Error path: done is high after edge 3.
- Output holding: K0, K1 and S_INNOV hold their values between runs and update only at their write cycles. K0 changes before K1 within a run; consumers sample only on done.
- Truncation mode: without the optional feature, the quotient is truncated toward zero.
- Saturation: the limits are 2^(N-1)-1 and -2^(N-1). There is no wrap-around.

Optional Feature:
- Macro: KGAIN_RND_EN.
- Defined:
  - DIV_ITERS = N+FRAC+1; the extra LSB is a guard bit.
  - Magnitude quotient = (q + 1) >> 1, i.e. round half away from zero, applied before sign and saturation.
  - Latency becomes done after edge 65.
- Undefined: truncation as described above; DIV_ITERS = 30.

Decomposition:
- Shared package kf_pkg holds:
  - N/FRAC defaults and the state encoding localparams for IDLE/SUM/DIV0/DIV1/FIN.
  - sat_to_n function (signed saturation from a wider value to N bits).
  - The ONE constant = 1 << FRAC.
- Sub-module fxp_div_seq: unsigned restoring divider.
  - Ports: clk, rst, load, dividend[N+FRAC-1:0], divisor[N:0], busy, valid, quotient.
  - Iteration count is a parameter.
  - The top-level block handles sign, rounding and saturation.

Test Plan:
- Basic gain: p00=1024, p10=512, r=1024 -> S_INNOV=2048, K0=512, K1=256, div_err=0, done exactly at cycle 63.
- Negative cross term: p00=1024, p10=-512, r=1024 -> K0=512, K1=-256.
- Bad divisor: p00=0, r=0 -> div_err=1, K0=K1=0, done at cycle 3. Then a legal start clears div_err.
- Saturation: p00=1, p10=524287, r=0 -> K0=1024, K1=524287.
- Rounding: p00=1024, p10=2048, r=2048 -> K0=341. K1=682 without KGAIN_RND_EN, 683 with it.
- Control: start pulses during busy are ignored; back-to-back start on the done cycle is accepted; rst asserted at cycle 20 -> all outputs 0, no done pulse.

Source files
------------

// File: rtl/kf_pkg.sv
// Shared definitions for the Kalman-gain stage: format defaults, FSM encoding,
// the unity constant and signed saturation.
package kf_pkg;

    localparam int N_DEF    = 20;
    localparam int FRAC_DEF = 10;
    localparam int ONE      = 1 << FRAC_DEF;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SUM  = 3'd1;
    localparam logic [2:0] ST_DIV0 = 3'd2;
    localparam logic [2:0] ST_DIV1 = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        SUM  = ST_SUM,
        DIV0 = ST_DIV0,
        DIV1 = ST_DIV1,
        FIN  = ST_FIN
    } state_t;

    // Clamp a wide signed value into the signed n-bit range (no wrap-around).
    function automatic logic signed [63:0] sat_to_n(input logic signed [63:0] x, input int n);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/kalman_gain_seq_if.sv
// Request/result bundle between the prior-covariance stage, the gain stage and
// the posterior update stage.
interface kalman_gain_seq_if
    import kf_pkg::*;
#(
    parameter int N = N_DEF
);
    logic                start;
    logic signed [N-1:0] p00;
    logic signed [N-1:0] p10;
    logic signed [N-1:0] r;
    logic                busy;
    logic                done;
    logic                div_err;
    logic signed [N-1:0] S_INNOV;
    logic signed [N-1:0] K0;
    logic signed [N-1:0] K1;

    modport master (
        output start, p00, p10, r,
        input  busy, done, div_err, S_INNOV, K0, K1
    );

    modport slave (
        input  start, p00, p10, r,
        output busy, done, div_err, S_INNOV, K0, K1
    );
endinterface

// File: rtl/fxp_div_seq.sv
// Unsigned bit-serial restoring divider: one quotient bit per cycle, MSB first.
// The dividend is left-aligned in an ITERS-bit shifter so extra iterations yield guard bits.
module fxp_div_seq #(
    parameter int N     = 20,
    parameter int FRAC  = 10,
    parameter int ITERS = N + FRAC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [N+FRAC-1:0]  dividend,
    input  logic [N:0]         divisor,
    output logic               busy,
    output logic               valid,
    output logic [ITERS-1:0]   quotient
);
    localparam int DW = N + FRAC;
    localparam int CW = $clog2(ITERS + 1);

    logic [ITERS-1:0] num_sr;
    logic [N:0]       rem;
    logic [N:0]       dvs;
    logic [N+1:0]     shifted;
    logic [N:0]       diff;
    logic             fits;
    logic [CW-1:0]    cnt;

    // Remainder stays below the divisor, so the low N+1 bits of the difference are exact.
    assign shifted = {rem, num_sr[ITERS-1]};
    assign fits    = shifted >= {1'b0, dvs};
    assign diff    = shifted[N:0] - dvs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            valid <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            busy  <= 1'b1;
            valid <= 1'b0;
            cnt   <= CW'(ITERS);
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                busy  <= 1'b0;
                valid <= 1'b1;
            end
        end else begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            num_sr   <= ITERS'(dividend) << (ITERS - DW);
            rem      <= '0;
            dvs      <= divisor;
            quotient <= '0;
        end else if (busy) begin
            num_sr   <= num_sr << 1;
            rem      <= fits ? diff : shifted[N:0];
            quotient <= {quotient[ITERS-2:0], fits};
        end
    end

endmodule

// File: rtl/kalman_gain_seq.sv
// Innovation covariance S = P00 + r and gain K = [P00/S ; P10/S] via one shared serial divider.
// Optional macro KGAIN_RND_EN: one guard quotient bit and round-half-away-from-zero.
module kalman_gain_seq
    import kf_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input logic              clk,
    input logic              rst,
    kalman_gain_seq_if.slave bus
);
`ifdef KGAIN_RND_EN
    localparam int DIV_ITERS = N + FRAC + 1;
`else
    localparam int DIV_ITERS = N + FRAC;
`endif

    state_t              state;
    logic signed [N-1:0] p00_q;
    logic signed [N-1:0] p10_q;
    logic signed [N-1:0] r_q;
    logic signed [N:0]   s_q;
    logic signed [N:0]   s_sum;
    logic                sum_bad;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic signed [N-1:0] s_innov_q;
    logic signed [N-1:0] k0_q;
    logic signed [N-1:0] k1_q;

    logic                 accept;
    logic                 div_load;
    logic                 div_busy;
    logic                 div_valid;
    logic                 div_ready;
    logic [N+FRAC-1:0]    div_dividend;
    logic [N:0]           div_divisor;
    logic [DIV_ITERS-1:0] div_quot;

    function automatic logic [N-1:0] mag_n(input logic signed [N-1:0] x);
        return x[N-1] ? -x : x;
    endfunction

    // Magnitude quotient -> optional rounding -> numerator sign -> N-bit saturation.
    function automatic logic signed [N-1:0] gain_of(input logic [DIV_ITERS-1:0] q, input logic neg);
        logic [DIV_ITERS:0] m;
        logic signed [63:0] w;
`ifdef KGAIN_RND_EN
        m = ({1'b0, q} + {{DIV_ITERS{1'b0}}, 1'b1}) >> 1;
`else
        m = {1'b0, q};
`endif
        w = 64'(m);
        if (neg) w = -w;
        return N'(sat_to_n(w, N));
    endfunction

    assign accept       = bus.start && (state == IDLE || state == FIN);
    assign s_sum        = {p00_q[N-1], p00_q} + {r_q[N-1], r_q};
    assign sum_bad      = s_sum[N] || (s_sum == '0);
    assign div_ready    = div_valid && !div_busy;
    assign div_load     = (state == SUM && !sum_bad) || (state == DIV0 && div_ready && !err_q);
    assign div_dividend = {mag_n(state == SUM ? p00_q : p10_q), {FRAC{1'b0}}};
    assign div_divisor  = (state == SUM) ? s_sum : s_q;

    fxp_div_seq #(
        .N     (N),
        .FRAC  (FRAC),
        .ITERS (DIV_ITERS)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .valid    (div_valid),
        .quotient (div_quot)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            p00_q <= bus.p00;
            p10_q <= bus.p10;
            r_q   <= bus.r;
        end
        if (state == SUM) s_q <= s_sum;
    end

    // A bad divisor skips the divider but still passes through the two write slots,
    // so the error path keeps a fixed, short latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            s_innov_q <= '0;
            k0_q      <= '0;
            k1_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        err_q  <= 1'b0;
                        state  <= SUM;
                    end else begin
                        state <= IDLE;
                    end
                end
                SUM: begin
                    s_innov_q <= N'(sat_to_n({{(63 - N){s_sum[N]}}, s_sum}, N));
                    if (sum_bad) begin
                        err_q <= 1'b1;
                        k0_q  <= '0;
                        k1_q  <= '0;
                    end else begin
                        err_q <= 1'b0;
                    end
                    state <= DIV0;
                end
                DIV0: begin
                    if (err_q) begin
                        state <= DIV1;
                    end else if (div_ready) begin
                        k0_q  <= gain_of(div_quot, p00_q[N-1]);
                        state <= DIV1;
                    end
                end
                DIV1: begin
                    if (err_q || div_ready) begin
                        if (!err_q) k1_q <= gain_of(div_quot, p10_q[N-1]);
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.div_err = err_q;
    assign bus.S_INNOV = s_innov_q;
    assign bus.K0      = k0_q;
    assign bus.K1      = k1_q;

endmodule

// File: tb/tb_kalman_gain_seq.sv
// Self-checking bench for kalman_gain_seq: directed cases plus random runs against
// an arithmetic reference model (honours KGAIN_RND_EN).
module tb_kalman_gain_seq;
    localparam int N    = 20;
    localparam int FRAC = 10;
`ifdef KGAIN_RND_EN
    localparam int LAT = 65;
`else
    localparam int LAT = 63;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    kalman_gain_seq_if #(.N(N)) bus();

    kalman_gain_seq #(.N(N), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic longint clamp(input longint x);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (N - 1)) - 1;
        lo = -(longint'(1) <<< (N - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Reference gain: |p| * 2^FRAC / s, truncated or rounded half away from zero, signed, clamped.
    function automatic longint gain_ref(input longint p, input longint s);
        longint mag;
        longint q;
        mag = (p < 0) ? -p : p;
`ifdef KGAIN_RND_EN
        q = ((mag * (longint'(1) <<< (FRAC + 1))) / s + 1) / 2;
`else
        q = (mag * (longint'(1) <<< FRAC)) / s;
`endif
        return clamp((p < 0) ? -q : q);
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.done) n++;
        end
    endtask

    // Called at a safe point (#1 after an edge). Presents start for one edge, scrambles
    // the inputs afterwards, optionally pulses start mid-run, then checks the result.
    task automatic run_case(input string tag, input int a, input int b, input int c, input bit disturb);
        longint s;
        longint es;
        longint ek0;
        longint ek1;
        int     eerr;
        int     elat;
        int     lat;
        s  = longint'(a) + longint'(c);
        es = clamp(s);
        if (s <= 0) begin
            eerr = 1; ek0 = 0; ek1 = 0; elat = 3;
        end else begin
            eerr = 0; ek0 = gain_ref(a, s); ek1 = gain_ref(b, s); elat = LAT;
        end
        bus.p00   = N'(a);
        bus.p10   = N'(b);
        bus.r     = N'(c);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.p00   = N'($urandom);
        bus.p10   = N'($urandom);
        bus.r     = N'($urandom);
        check({tag, ".busy_on"}, bus.busy, 1);
        lat = -1;
        for (int cyc = 1; cyc <= LAT + 20; cyc++) begin
            if (disturb) bus.start = (cyc == 10);
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = cyc;
                break;
            end
        end
        bus.start = 1'b0;
        check({tag, ".latency"}, lat, elat);
        check({tag, ".s_innov"}, bus.S_INNOV, es);
        check({tag, ".k0"}, bus.K0, ek0);
        check({tag, ".k1"}, bus.K1, ek1);
        check({tag, ".div_err"}, bus.div_err, eerr);
        check({tag, ".busy_off"}, bus.busy, 0);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.p00   = '0;
        bus.p10   = '0;
        bus.r     = '0;
        idle(2);
        check("rst.s_innov", bus.S_INNOV, 0);
        check("rst.k0", bus.K0, 0);
        check("rst.k1", bus.K1, 0);
        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        check("rst.div_err", bus.div_err, 0);
        rst = 1'b0;
        idle(1);

        run_case("basic", 1024, 512, 1024, 0);
        check("basic.k0_const", bus.K0, 512);
        check("basic.k1_const", bus.K1, 256);
        check("basic.s_const", bus.S_INNOV, 2048);
        idle(1);
        check("basic.done_pulse", bus.done, 0);
        idle(2);

        run_case("neg_cross", 1024, -512, 1024, 0);
        check("neg_cross.k1_const", bus.K1, -256);
        idle(2);

        run_case("bad_div", 0, 300, 0, 0);
        check("bad_div.err_const", bus.div_err, 1);
        idle(2);
        run_case("clear_err", 1024, 512, 1024, 0);

        // Back-to-back: the next start is presented in the cycle done is high.
        run_case("sat", 1, 524287, 0, 0);
        check("sat.k0_const", bus.K0, 1024);
        check("sat.k1_const", bus.K1, 524287);
        run_case("round", 1024, 2048, 2048, 0);
        check("round.k0_const", bus.K0, 341);
`ifdef KGAIN_RND_EN
        check("round.k1_const", bus.K1, 683);
`else
        check("round.k1_const", bus.K1, 682);
`endif
        idle(2);

        run_case("ignore", 3000, -7000, 500, 1);
        count_dones(LAT + 10, n);
        check("ignore.no_extra_done", n, 0);

        run_case("neg_p00", -300, 900, 2000, 0);
        run_case("min_p10", 700, -524288, 1, 0);
        idle(1);

        for (int i = 0; i < 8; i++) begin
            run_case($sformatf("rand%0d", i),
                     int'($urandom_range(0, 20000)) - 2000,
                     int'($urandom_range(0, 1048575)) - 524288,
                     int'($urandom_range(0, 5000)),
                     1'b0);
            idle(i % 3);
        end

        // Abort mid-run with an asynchronous reset while outputs still hold earlier values.
        bus.p00   = N'(1024);
        bus.p10   = N'(512);
        bus.r     = N'(1024);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("abort.s_innov", bus.S_INNOV, 0);
        check("abort.k0", bus.K0, 0);
        check("abort.k1", bus.K1, 0);
        check("abort.busy", bus.busy, 0);
        check("abort.div_err", bus.div_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_dones(LAT + 10, n);
        check("abort.no_done", n, 0);
        run_case("after_abort", 2048, -1024, 1024, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
